// File: rtl/ntt_pipeline_sequencer.sv
// ntt_pipeline_sequencer
// Admits polynomial frames into the non-stallable NTT datapath, frames the
// datapath output, enforces in-flight/output-buffer credits and checks that
// the datapath latency matches PIPE_LATENCY exactly.
module ntt_pipeline_sequencer #(
    parameter int BEATS_PER_FRAME = 16,
    parameter int PIPE_LATENCY    = 40,
    parameter int MAX_INFLIGHT    = 4,
    parameter int CREDITS         = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic s_valid,
    output logic s_ready,
    output logic pipe_start,
    input  logic pipe_done,
    input  logic credit_return,
    output logic m_valid,
    output logic m_last,
    output logic frame_done,
    output logic err_underrun,
    output logic err_latency,
    output logic err_overlap,
    output logic err_credit
);

    localparam int CNT_W = (BEATS_PER_FRAME > 1) ? $clog2(BEATS_PER_FRAME) : 1;
    localparam int IFL_W = $clog2(MAX_INFLIGHT + 1);
    localparam int CRD_W = $clog2(CREDITS + 1);

    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS_PER_FRAME - 1);
    localparam logic [IFL_W-1:0] MAX_IFL   = IFL_W'(MAX_INFLIGHT);
    localparam logic [CRD_W-1:0] FULL_CRD  = CRD_W'(CREDITS);

    typedef enum logic {
        S_IDLE,
        S_STREAM
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [CNT_W-1:0]   r_in_cnt;
    logic [CNT_W-1:0]   w_in_cnt_nxt;
    logic [CNT_W-1:0]   r_out_cnt;
    logic [CNT_W-1:0]   w_out_cnt_nxt;
    logic [IFL_W-1:0]   r_inflight;
    logic [CRD_W-1:0]   r_credits;
    logic [PIPE_LATENCY-1:0] r_dly;
    logic               r_frame_done;
    logic               r_err_underrun;
    logic               r_err_latency;
    logic               r_err_overlap;
    logic               r_err_credit;

    logic w_admit_ok;
    logic w_s_ready;
    logic w_start;
    logic w_underrun_now;
    logic w_out_active;
    logic w_m_valid;
    logic w_m_last;
    logic w_tap;
    logic w_done_dec;
    logic w_crd_inc;
    logic w_latency_now;
    logic w_overlap_now;
    logic w_credit_now;

    // A frame may only start when a downstream buffer is free and the
    // datapath has room for another frame in flight.
    assign w_admit_ok = (r_credits != '0) && (r_inflight < MAX_IFL);

    // Input FSM: admission decision in IDLE, unconditional beat counting in STREAM.
    always_comb begin
        w_state_nxt    = r_state;
        w_in_cnt_nxt   = r_in_cnt;
        w_s_ready      = 1'b0;
        w_start        = 1'b0;
        w_underrun_now = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_s_ready = w_admit_ok;
                if (s_valid && w_admit_ok) begin
                    w_start = 1'b1;
                    if (LAST_BEAT == '0) begin
                        w_state_nxt  = S_IDLE;
                        w_in_cnt_nxt = '0;
                    end else begin
                        w_state_nxt  = S_STREAM;
                        w_in_cnt_nxt = CNT_W'(1);
                    end
                end
            end
            S_STREAM: begin
                // The datapath cannot stall, so a missing beat becomes a bubble.
                w_s_ready      = 1'b1;
                w_underrun_now = !s_valid;
                if (r_in_cnt == LAST_BEAT) begin
                    w_state_nxt  = S_IDLE;
                    w_in_cnt_nxt = '0;
                end else begin
                    w_in_cnt_nxt = r_in_cnt + CNT_W'(1);
                end
            end
            default: begin
                w_state_nxt  = S_IDLE;
                w_in_cnt_nxt = '0;
            end
        endcase
        if (rst) begin
            w_s_ready      = 1'b0;
            w_start        = 1'b0;
            w_underrun_now = 1'b0;
        end
    end

    // Output framing: a pipe_done seen while idle opens a frame of exactly
    // BEATS_PER_FRAME beats; a pipe_done inside a running frame is dropped.
    assign w_out_active  = (r_out_cnt != '0);
    assign w_m_valid     = !rst && (w_out_active || pipe_done);
    assign w_m_last      = w_m_valid && (r_out_cnt == LAST_BEAT);
    assign w_out_cnt_nxt = !w_m_valid ? r_out_cnt :
                           (r_out_cnt == LAST_BEAT) ? '0 : r_out_cnt + CNT_W'(1);

    // Latency check: the delay-line tap must equal pipe_done every cycle.
    assign w_tap         = r_dly[PIPE_LATENCY-1];
    assign w_done_dec    = pipe_done && (r_inflight != '0);
    assign w_latency_now = !rst && ((w_tap != pipe_done) || (pipe_done && r_inflight == '0));
    assign w_overlap_now = !rst && pipe_done && w_out_active;

    // A return that coincides with an admit is always absorbable.
    assign w_crd_inc     = credit_return && ((r_credits != FULL_CRD) || w_start);
    assign w_credit_now  = !rst && credit_return && !w_start && (r_credits == FULL_CRD);

    // FSM state and beat counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= S_IDLE;
            r_in_cnt  <= '0;
            r_out_cnt <= '0;
        end else begin
            r_state   <= w_state_nxt;
            r_in_cnt  <= w_in_cnt_nxt;
            r_out_cnt <= w_out_cnt_nxt;
        end
    end

    // Delay line of pipe_start, PIPE_LATENCY deep.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dly <= '0;
        end else begin
            r_dly[0] <= w_start;
            for (int i = 1; i < PIPE_LATENCY; i++) begin
                r_dly[i] <= r_dly[i-1];
            end
        end
    end

    // Frames in flight: simultaneous start and done cancel out.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_inflight <= '0;
        end else begin
            case ({w_start, w_done_dec})
                2'b10:   r_inflight <= r_inflight + IFL_W'(1);
                2'b01:   r_inflight <= r_inflight - IFL_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    // Downstream buffer credits, saturating at CREDITS.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_credits <= FULL_CRD;
        end else begin
            case ({w_start, w_crd_inc})
                2'b10:   r_credits <= r_credits - CRD_W'(1);
                2'b01:   r_credits <= r_credits + CRD_W'(1);
                default: r_credits <= r_credits;
            endcase
        end
    end

    // Registered frame_done and sticky error flags.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_frame_done   <= 1'b0;
            r_err_underrun <= 1'b0;
            r_err_latency  <= 1'b0;
            r_err_overlap  <= 1'b0;
            r_err_credit   <= 1'b0;
        end else begin
            r_frame_done   <= w_m_last;
            r_err_underrun <= r_err_underrun | w_underrun_now;
            r_err_latency  <= r_err_latency  | w_latency_now;
            r_err_overlap  <= r_err_overlap  | w_overlap_now;
            r_err_credit   <= r_err_credit   | w_credit_now;
        end
    end

    // Error outputs also show the offending cycle itself, not only later ones.
    assign s_ready      = w_s_ready;
    assign pipe_start   = w_start;
    assign m_valid      = w_m_valid;
    assign m_last       = w_m_last;
    assign frame_done   = r_frame_done;
    assign err_underrun = !rst && (r_err_underrun | w_underrun_now);
    assign err_latency  = !rst && (r_err_latency  | w_latency_now);
    assign err_overlap  = !rst && (r_err_overlap  | w_overlap_now);
    assign err_credit   = !rst && (r_err_credit   | w_credit_now);

endmodule

// File: tb/tb_ntt_pipeline_sequencer.sv
// Testbench for ntt_pipeline_sequencer: table-driven single-frame check,
// hand-written corner sequences and a randomized run against a frame-level model.
module tb_ntt_pipeline_sequencer;

    localparam int BPF  = 16;
    localparam int LAT  = 40;
    localparam int MAXF = 4;
    localparam int CRD  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic s_valid = 1'b0;
    logic pipe_done = 1'b0;
    logic credit_return = 1'b0;
    logic s_ready, pipe_start, m_valid, m_last, frame_done;
    logic err_underrun, err_latency, err_overlap, err_credit;

    int n_cmp = 0;
    int n_bad = 0;

    ntt_pipeline_sequencer #(
        .BEATS_PER_FRAME(BPF),
        .PIPE_LATENCY(LAT),
        .MAX_INFLIGHT(MAXF),
        .CREDITS(CRD)
    ) dut (
        .clk(clk),
        .rst(rst),
        .s_valid(s_valid),
        .s_ready(s_ready),
        .pipe_start(pipe_start),
        .pipe_done(pipe_done),
        .credit_return(credit_return),
        .m_valid(m_valid),
        .m_last(m_last),
        .frame_done(frame_done),
        .err_underrun(err_underrun),
        .err_latency(err_latency),
        .err_overlap(err_overlap),
        .err_credit(err_credit)
    );

    always #5 clk = ~clk;

    // {s_ready, pipe_start, m_valid, m_last, frame_done, err_underrun, err_latency, err_overlap, err_credit}
    function automatic logic [8:0] outs();
        return {s_ready, pipe_start, m_valid, m_last, frame_done,
                err_underrun, err_latency, err_overlap, err_credit};
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // One clock cycle: inputs change just after the edge, outputs are read mid-cycle.
    task automatic apply(input logic r, input logic sv, input logic pd, input logic cr);
        @(posedge clk);
        #1;
        rst = r; s_valid = sv; pipe_done = pd; credit_return = cr;
        #4;
    endtask

    // ---------------- frame-level reference model ----------------
    int m_cyc, m_in_pos, m_out_pos, m_inflight, m_credits;
    bit m_last_prev, m_e_und, m_e_lat, m_e_ovl, m_e_crd;
    int m_starts[$];

    task automatic model_reset();
        m_cyc = 0; m_in_pos = -1; m_out_pos = -1; m_inflight = 0; m_credits = CRD;
        m_last_prev = 0; m_e_und = 0; m_e_lat = 0; m_e_ovl = 0; m_e_crd = 0;
        m_starts.delete();
    endtask

    function automatic bit model_due();
        if (m_starts.size() == 0) return 1'b0;
        return (m_starts[0] + LAT == m_cyc);
    endfunction

    task automatic model_step(input bit sv, input bit pd, input bit cr, output logic [8:0] e);
        bit admit, ready, start, due, mv, ml, crd_err;
        int idx;
        admit = (m_credits > 0) && (m_inflight < MAXF);
        if (m_in_pos < 0) begin ready = admit; start = sv && admit; end
        else begin ready = 1'b1; start = 1'b0; end
        due = model_due();
        mv  = (m_out_pos >= 0) || pd;
        idx = (m_out_pos >= 0) ? m_out_pos : 0;
        ml  = mv && (idx == BPF - 1);
        crd_err = cr && !start && (m_credits == CRD);
        m_e_und |= (m_in_pos >= 0) && !sv;
        m_e_lat |= (pd != due) || (pd && m_inflight == 0);
        m_e_ovl |= pd && (m_out_pos >= 0);
        m_e_crd |= crd_err;
        e = {ready, start, mv, ml, m_last_prev, m_e_und, m_e_lat, m_e_ovl, m_e_crd};
        if (due) void'(m_starts.pop_front());
        if (start) m_starts.push_back(m_cyc);
        if (m_in_pos < 0) m_in_pos = start ? 1 : -1;
        else m_in_pos = (m_in_pos == BPF - 1) ? -1 : m_in_pos + 1;
        m_inflight = m_inflight + (start ? 1 : 0) - ((pd && m_inflight > 0) ? 1 : 0);
        m_credits  = m_credits - (start ? 1 : 0) + ((cr && !crd_err) ? 1 : 0);
        if (m_out_pos >= 0) m_out_pos = (idx == BPF - 1) ? -1 : idx + 1;
        else m_out_pos = pd ? 1 : -1;
        m_last_prev = ml;
        m_cyc++;
    endtask

    task automatic do_reset();
        apply(1, 0, 0, 0);
        apply(1, 0, 0, 0);
        model_reset();
    endtask

    typedef struct {
        logic       sv;
        logic       pd;
        logic       cr;
        logic [8:0] exp;
    } vec_t;

    vec_t tbl[60];

    initial begin
        logic [8:0] e;
        int  mv_cnt;
        bit  bad_flag;
        bit  sv, pd, cr;

        // Single frame: start at 0, pipe_done at LAT, output framing afterwards.
        for (int c = 0; c < 60; c++) begin
            tbl[c].sv  = (c < BPF);
            tbl[c].pd  = (c == LAT);
            tbl[c].cr  = 1'b0;
            tbl[c].exp = {1'b1, c == 0, (c >= LAT) && (c < LAT + BPF),
                          c == LAT + BPF - 1, c == LAT + BPF, 4'b0000};
        end

        // Reset state: every output low while rst is high.
        apply(1, 0, 0, 0);
        apply(1, 1, 1, 1);
        chk("reset_outputs", 32'(outs()), 32'h0);
        apply(1, 0, 0, 0);
        model_reset();

        for (int c = 0; c < 60; c++) begin
            apply(0, tbl[c].sv, tbl[c].pd, tbl[c].cr);
            chk($sformatf("t1_cycle%0d", c), 32'(outs()), 32'(tbl[c].exp));
        end

        // Credit exhaustion: two frames, then blocked until one credit returns.
        do_reset();
        for (int c = 0; c < 37; c++) begin
            apply(0, 1, 0, (c == 36));
            if (c < 32)
                chk($sformatf("t2_ready_start_c%0d", c), 32'({s_ready, pipe_start}),
                    32'({1'b1, (c == 0) || (c == 16)}));
            else
                chk($sformatf("t2_blocked_c%0d", c), 32'({s_ready, pipe_start}), 32'h0);
        end
        apply(0, 1, 0, 0);
        chk("t2_third_frame_start", 32'({s_ready, pipe_start}), 32'h3);
        chk("t2_no_errors", 32'(outs() & 9'h00F), 32'h0);

        // Early pipe_done: latency error raised on that cycle and sticky.
        do_reset();
        for (int c = 0; c <= 70; c++) begin
            apply(0, (c < BPF), (c == LAT - 1), 0);
            if (c == LAT - 2) chk("t3_latency_before", 32'(err_latency), 32'h0);
            if (c == LAT - 1) chk("t3_latency_at_39", 32'(err_latency), 32'h1);
            if (c == 70)      chk("t3_latency_sticky", 32'(err_latency), 32'h1);
        end

        // Underrun at beat 7: frame still ends on schedule.
        do_reset();
        for (int c = 0; c <= 16; c++) begin
            apply(0, (c != 7), 0, 0);
            if (c == 6)  chk("t4_underrun_before", 32'(err_underrun), 32'h0);
            if (c == 7)  chk("t4_underrun_set", 32'(err_underrun), 32'h1);
            if (c == 15) chk("t4_last_beat", 32'({s_ready, pipe_start}), 32'h2);
            if (c == 16) chk("t4_next_admit", 32'({s_ready, pipe_start, err_underrun}), 32'h7);
        end

        // Overlapping pipe_done 8 cycles after the first.
        do_reset();
        mv_cnt = 0;
        for (int c = 0; c <= 60; c++) begin
            apply(0, (c < BPF), (c == LAT) || (c == LAT + 8), 0);
            if (m_valid) mv_cnt++;
            if (c == LAT + 7) chk("t5_overlap_before", 32'(err_overlap), 32'h0);
            if (c == LAT + 8) chk("t5_overlap_set", 32'({err_overlap, m_valid}), 32'h3);
            if (c == LAT + BPF - 1) chk("t5_mlast", 32'(m_last), 32'h1);
            if (c == LAT + BPF) chk("t5_after_frame", 32'({m_valid, frame_done}), 32'h1);
        end
        chk("t5_mvalid_cycles", 32'(mv_cnt), 32'd16);

        // Reset during output beat 5 abandons the output frame.
        do_reset();
        for (int c = 0; c < LAT + 5; c++) apply(0, (c < BPF), (c == LAT), 0);
        chk("t6_beat4_valid", 32'(m_valid), 32'h1);
        apply(1, 0, 0, 0);
        apply(0, 0, 0, 0);
        chk("t6_mvalid_off", 32'(m_valid), 32'h0);
        chk("t6_credits", 32'(dut.r_credits), 32'd2);
        chk("t6_inflight", 32'(dut.r_inflight), 32'd0);
        chk("t6_errors", 32'(outs() & 9'h00F), 32'h0);
        bad_flag = 0;
        for (int c = 0; c < 40; c++) begin
            apply(0, 0, 0, 0);
            if (m_valid || (outs() & 9'h00F) != 0) bad_flag = 1;
        end
        chk("t6_quiet_after_reset", 32'(bad_flag), 32'h0);

        // Randomized: clean datapath first, then with injected glitches.
        for (int phase = 0; phase < 2; phase++) begin
            do_reset();
            for (int i = 0; i < 700; i++) begin
                sv = ($urandom_range(0, 9) != 0);
                pd = model_due();
                cr = (m_credits < CRD) && ($urandom_range(0, 7) == 0);
                if (phase == 1) begin
                    if ($urandom_range(0, 199) == 0) pd = !pd;
                    if ($urandom_range(0, 49) == 0) cr = 1'b1;
                end
                apply(0, sv, pd, cr);
                model_step(sv, pd, cr, e);
                chk($sformatf("rnd_p%0d_c%0d", phase, i), 32'(outs()), 32'(e));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
